// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline hazard / CGRA-offload controller:
//   - 2-bit FSM state encodings (as localparams and a typed enum)
//   - the NOP instruction and bubble control word that the flushed stage
//     registers load when if_id_flush_o / id_ex_flush_o are asserted
//   - load-use detection helper
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_START   = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        START   = ST_START,
        WAIT    = ST_WAIT,
        RELEASE = ST_RELEASE
    } hz_state_e;

    // addi x0, x0, 0 -- what IF/ID holds after a flush.
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    // ID/EX control word after a flush: every control bit cleared.
    localparam logic [15:0] BUBBLE_CTRL = 16'h0000;

    // A load in EX whose destination feeds the instruction in ID.
    // x0 is never a real dependency.
    function automatic logic is_load_use(
        input logic       ex_mem_read,
        input logic [4:0] ex_rd,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt
    );
        return ex_mem_read && (ex_rd != 5'd0) &&
               ((ex_rd == id_rs) || (ex_rd == id_rt));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_cgra_handshake_fsm.sv
// -----------------------------------------------------------------------------
// cgra_handshake_fsm
// Sequences one CGRA offload: IDLE -> START (one-cycle start pulse) -> WAIT
// (until done or timeout) -> RELEASE (one cycle, lets the op advance to EX).
// Owns the timeout counter and the sticky error flag.
//
// Ports
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   req_i          launch request, only honoured in IDLE
//   done_i         CGRA completion level, sampled only in WAIT
//   state_o        current FSM state (pipe_ctrl_pkg encoding)
//   cgra_start_o   registered start pulse, high for the START cycle
//   cgra_err_o     registered sticky timeout flag
// -----------------------------------------------------------------------------
module cgra_handshake_fsm
    import pipe_ctrl_pkg::*;
#(
    parameter int CGRA_TIMEOUT = 1024
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req_i,
    input  logic       done_i,
    output logic [1:0] state_o,
    output logic       cgra_start_o,
    output logic       cgra_err_o
);

    localparam int              CNT_W   = $clog2(CGRA_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(CGRA_TIMEOUT - 1);

    hz_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = cgra_err_o;
        case (state_q)
            IDLE: begin
                if (req_i) state_d = START;
            end
            START: begin
                // Clearing here is what keeps the counter from ever wrapping.
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (done_i) begin
                    // Done takes precedence over a coincident timeout.
                    state_d = RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == TO_LAST) begin
                        err_d   = 1'b1;
                        state_d = RELEASE;
                    end
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            cgra_start_o <= 1'b0;
            cgra_err_o   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cgra_start_o <= (state_d == START);
            cgra_err_o   <= err_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Stall/flush controller for the PC, IF/ID and ID/EX stage registers of the
// five-stage core: load-use stalls, taken-branch flushes and front-end stall
// while a CGRA op in ID runs through the start/done handshake.
//
// Optional feature macro: HAZARD_PERF_CNT_EN adds stall_cnt_o, a saturating
// count of cycles with pc_stall_o high.
//
// Parameters
//   CGRA_TIMEOUT     max WAIT cycles before cgra_err_o is raised (>= 2)
// Ports
//   clk_i            clock, rising edge
//   start_i          asynchronous active-low reset
//   id_rs_addr_i     rs of the instruction in ID
//   id_rt_addr_i     rt of the instruction in ID
//   ex_rd_addr_i     rd of the instruction in EX
//   ex_mem_read_i    instruction in EX is a load
//   branch_taken_i   branch resolved taken in EX
//   id_cgra_inst_i   instruction in ID is a CGRA offload op
//   cgra_done_i      CGRA completion level
//   pc_stall_o       hold PC
//   if_id_stall_o    hold IF/ID
//   if_id_flush_o    load NOP into IF/ID
//   id_ex_flush_o    load bubble into ID/EX
//   cgra_start_o     registered start pulse to the CGRA
//   cgra_err_o       sticky CGRA timeout flag
//   stall_cnt_o      (HAZARD_PERF_CNT_EN only) stall cycle counter
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CGRA_TIMEOUT = 1024
) (
    input  logic        clk_i,
    input  logic        start_i,
    input  logic [4:0]  id_rs_addr_i,
    input  logic [4:0]  id_rt_addr_i,
    input  logic [4:0]  ex_rd_addr_i,
    input  logic        ex_mem_read_i,
    input  logic        branch_taken_i,
    input  logic        id_cgra_inst_i,
    input  logic        cgra_done_i,
    output logic        pc_stall_o,
    output logic        if_id_stall_o,
    output logic        if_id_flush_o,
    output logic        id_ex_flush_o,
    output logic        cgra_start_o,
    output logic        cgra_err_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt_o
`endif
);

    logic [1:0] state;
    logic       lu;
    logic       busy;
    logic       cgra_req;

    assign lu   = is_load_use(ex_mem_read_i, ex_rd_addr_i, id_rs_addr_i, id_rt_addr_i);
    // START and WAIT freeze the front end; EX only sees bubbles, so a branch
    // cannot resolve there.
    assign busy = (state == ST_START) || (state == ST_WAIT);
    // Only IDLE launches; in RELEASE the CGRA op is still in ID for one more
    // cycle and must not be launched a second time.
    assign cgra_req = start_i && (state == ST_IDLE) && id_cgra_inst_i &&
                      !branch_taken_i && !lu;

    cgra_handshake_fsm #(
        .CGRA_TIMEOUT (CGRA_TIMEOUT)
    ) u_fsm (
        .clk_i        (clk_i),
        .rst_ni       (start_i),
        .req_i        (cgra_req),
        .done_i       (cgra_done_i),
        .state_o      (state),
        .cgra_start_o (cgra_start_o),
        .cgra_err_o   (cgra_err_o)
    );

    always_comb begin
        pc_stall_o    = 1'b0;
        if_id_stall_o = 1'b0;
        if_id_flush_o = 1'b0;
        id_ex_flush_o = 1'b0;
        if (!start_i) begin
            // Held in reset: everything quiet regardless of inputs.
        end else if (busy) begin
            pc_stall_o    = 1'b1;
            if_id_stall_o = 1'b1;
            id_ex_flush_o = 1'b1;
        end else if (branch_taken_i) begin
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
        end else if (lu) begin
            pc_stall_o    = 1'b1;
            if_id_stall_o = 1'b1;
            id_ex_flush_o = 1'b1;
        end else if (cgra_req) begin
            pc_stall_o    = 1'b1;
            if_id_stall_o = 1'b1;
            id_ex_flush_o = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            stall_cnt_o <= '0;
        end else if (pc_stall_o && (stall_cnt_o != 32'hFFFF_FFFF)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed bench for pipe_hazard_ctrl with CGRA_TIMEOUT = 4. Each step drives
// the inputs for one cycle, queues the expected output word
// {pc_stall, if_id_stall, if_id_flush, id_ex_flush, cgra_start, cgra_err}
// and compares it on the falling edge.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    logic        clk_i = 1'b0;
    logic        start_i;
    logic [4:0]  id_rs_addr_i, id_rt_addr_i, ex_rd_addr_i;
    logic        ex_mem_read_i, branch_taken_i, id_cgra_inst_i, cgra_done_i;
    logic        pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_flush_o;
    logic        cgra_start_o, cgra_err_o;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_o;
`endif

    typedef struct {
        logic [5:0] v;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam logic [5:0] Z   = 6'b000000;
    localparam logic [5:0] STL = 6'b110100;
    localparam logic [5:0] STS = 6'b110110;
    localparam logic [5:0] FLS = 6'b001100;
    localparam logic [5:0] ERR = 6'b000001;
    localparam logic [5:0] STE = 6'b110101;
    localparam logic [5:0] SSE = 6'b110111;

    always #5 clk_i = ~clk_i;

    pipe_hazard_ctrl #(
        .CGRA_TIMEOUT (4)
    ) dut (
        .clk_i          (clk_i),
        .start_i        (start_i),
        .id_rs_addr_i   (id_rs_addr_i),
        .id_rt_addr_i   (id_rt_addr_i),
        .ex_rd_addr_i   (ex_rd_addr_i),
        .ex_mem_read_i  (ex_mem_read_i),
        .branch_taken_i (branch_taken_i),
        .id_cgra_inst_i (id_cgra_inst_i),
        .cgra_done_i    (cgra_done_i),
        .pc_stall_o     (pc_stall_o),
        .if_id_stall_o  (if_id_stall_o),
        .if_id_flush_o  (if_id_flush_o),
        .id_ex_flush_o  (id_ex_flush_o),
        .cgra_start_o   (cgra_start_o),
        .cgra_err_o     (cgra_err_o)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt_o    (stall_cnt_o)
`endif
    );

    task automatic check_pop();
        exp_t       e;
        logic [5:0] obs;
        obs = {pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_flush_o,
               cgra_start_o, cgra_err_o};
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_empty observed=%b required=queued entry", obs);
        end else begin
            e = sb.pop_front();
            n_tests++;
            assert (obs === e.v) else begin
                n_fail++;
                $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic mr, input logic br,
                          input logic cg, input logic dn);
        id_rs_addr_i   = rs;
        id_rt_addr_i   = rt;
        ex_rd_addr_i   = rd;
        ex_mem_read_i  = mr;
        branch_taken_i = br;
        id_cgra_inst_i = cg;
        cgra_done_i    = dn;
    endtask

    // One clock cycle: drive inputs after the edge, queue expectation,
    // compare at the falling edge.
    task automatic cyc(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic mr, input logic br,
                       input logic cg, input logic dn,
                       input logic [5:0] ev, input string tag);
        @(posedge clk_i);
        #1;
        set_in(rs, rt, rd, mr, br, cg, dn);
        sb.push_back('{ev, tag});
        @(negedge clk_i);
        check_pop();
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic check_cnt(input logic [31:0] ev, input string tag);
        n_tests++;
        assert (stall_cnt_o === ev) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, stall_cnt_o, ev);
        end
    endtask
`endif

    initial begin
        start_i = 1'b0;
        set_in(5'd5, 5'd7, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);

        // Reset: a live load-use and CGRA op must not leak through.
        cyc(5'd5, 5'd7, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, Z, "reset_lu");
        cyc(5'd5, 5'd7, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, Z, "reset_br");
`ifdef HAZARD_PERF_CNT_EN
        check_cnt(32'd0, "cnt_reset");
`endif
        @(posedge clk_i);
        #1;
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        start_i = 1'b1;

        // Load-use: lw x5 in EX, add x6,x5,x7 in ID.
        cyc(5'd5, 5'd7, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, STL, "lu_rs");
        cyc(5'd6, 5'd7, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, Z,   "lu_gone");
        cyc(5'd0, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, Z,   "lu_x0");
        cyc(5'd5, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, STL, "lu_rt");
        cyc(5'd5, 5'd7, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, Z,   "no_load");

        // Branch beats load-use and discards a CGRA op in ID.
        cyc(5'd5, 5'd7, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, FLS, "br_over_lu");
        cyc(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0, FLS, "br_over_cgra");
        cyc(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, Z,   "no_start_after_br");

        // CGRA op at T, done on the 4th WAIT cycle (coincides with timeout).
        cyc(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, STL, "cg_T");
        cyc(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, STS, "cg_start");
        cyc(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, STL, "cg_wait1");
        cyc(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0, STL, "cg_wait2_br");
        cyc(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, STL, "cg_wait3");
        cyc(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, STL, "cg_wait4_done");
        cyc(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, Z,   "cg_release");
        cyc(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, Z,   "cg_idle");

        // Minimum stall, with a load-use evaluated during RELEASE.
        cyc(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, STL, "min_T");
        cyc(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, STS, "min_start");
        cyc(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, STL, "min_done");
        cyc(5'd9, 5'd2, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, STL, "rel_lu");
        cyc(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, Z,   "rel_lu_after");

        // Timeout: done never arrives.
        cyc(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, STL, "to_T");
        cyc(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, STS, "to_start");
        for (int i = 0; i < 4; i++)
            cyc(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, STL, "to_wait");
        cyc(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, ERR, "to_release_err");
        cyc(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, ERR, "err_sticky1");
        cyc(5'd5, 5'd7, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, STE, "err_sticky_lu");

        // Reset asserted mid-WAIT: outputs drop at once, error cleared.
        cyc(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, STE, "rw_T");
        cyc(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, SSE, "rw_start");
        cyc(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, STE, "rw_wait");
        @(posedge clk_i);
        #2;
        start_i = 1'b0;
        sb.push_back('{Z, "rw_reset"});
        #1;
        check_pop();
`ifdef HAZARD_PERF_CNT_EN
        check_cnt(32'd0, "cnt_rw_reset");
`endif
        @(negedge clk_i);
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        start_i = 1'b1;

        // Fresh minimal CGRA after reset: state really returned to IDLE.
        cyc(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, Z,   "post_idle");
        cyc(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, STL, "post_T");
        cyc(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, STS, "post_start");
        cyc(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, STL, "post_done");
        cyc(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, Z,   "post_release");
`ifdef HAZARD_PERF_CNT_EN
        check_cnt(32'd3, "cnt_three");
`endif
        cyc(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, Z,   "post_idle2");

        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_leftover observed=%0d entries required=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
